// File: rtl/aximm_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aximm_request_arbiter
// Purpose  : Round-robin arbiter sharing one AXI-MM-over-stream server among
//            up to four requesters. One transaction is outstanding at a time.
//            Malformed requests and stale server responses are discarded.
//            A DECERR response is synthesized if the server stays silent.
// Ports    : clk, reset                        - clock, sync active-high reset
//            REQ_TDATA/TVALID/TREADY           - per-requester request streams
//            RSP_TDATA/TVALID/TLAST/TREADY     - per-requester response streams
//            SRV_TX_TDATA/TVALID/TLAST/TREADY  - request stream to the server
//            SRV_RX_TDATA/TVALID/TREADY        - response stream from the server
//            TIMEOUT_COUNT, DROP_COUNT         - saturating event counters
// Revision : 1.0 - initial release
// ============================================================================
module aximm_request_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ*256-1:0]   REQ_TDATA,
  input  logic [NUM_REQ-1:0]       REQ_TVALID,
  output logic [NUM_REQ-1:0]       REQ_TREADY,
  output logic [255:0]             RSP_TDATA,
  output logic [NUM_REQ-1:0]       RSP_TVALID,
  output logic                     RSP_TLAST,
  input  logic [NUM_REQ-1:0]       RSP_TREADY,
  output logic [255:0]             SRV_TX_TDATA,
  output logic                     SRV_TX_TVALID,
  output logic                     SRV_TX_TLAST,
  input  logic                     SRV_TX_TREADY,
  input  logic [255:0]             SRV_RX_TDATA,
  input  logic                     SRV_RX_TVALID,
  output logic                     SRV_RX_TREADY,
  output logic [15:0]              TIMEOUT_COUNT,
  output logic [15:0]              DROP_COUNT
);

  localparam int          GW             = 2;
  localparam logic [31:0] TYPE_READ_REQ  = 32'd1;
  localparam logic [31:0] TYPE_WRITE_REQ = 32'd2;
  localparam logic [31:0] RESP_DECERR    = 32'd3;
  localparam logic [15:0] TIMER_LAST     = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FWD      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DELIVER  = 2'd3
  } state_t;

  state_t               state_q;
  logic [GW-1:0]        last_grant_q;
  logic [GW-1:0]        grant_q;
  logic [15:0]          timer_q;
  logic [255:0]         tx_data_q;
  logic                 tx_valid_q;
  logic [255:0]         rsp_data_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 rx_ready_q;
  logic [15:0]          timeout_cnt_q;
  logic [15:0]          drop_cnt_q;

  logic [GW-1:0]        grant_d;
  logic                 grant_vld_d;
  logic [255:0]         req_data_d;
  logic                 req_type_ok_d;
  logic [255:0]         rsp_synth_d;
  logic                 drop_req_d;
  logic                 drop_stale_d;
  logic                 timeout_evt_d;
  logic                 rsp_hs_d;
  logic [1:0]           drop_inc_d;

  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] n);
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] g);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      oh[i] = (int'(g) == i);
    end
    return oh;
  endfunction

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int idx;
    idx         = 0;
    grant_d     = '0;
    grant_vld_d = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_vld_d && (idx == i) && REQ_TVALID[i]) begin
          grant_vld_d = 1'b1;
          grant_d     = GW'(i);
        end
      end
    end
  end

  always_comb begin
    req_data_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(grant_d) == i) begin
        req_data_d = REQ_TDATA[i*256 +: 256];
      end
    end
  end

  // Ready is combinational so the grant can be taken in the same cycle it
  // is computed; it is suppressed during reset.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      REQ_TREADY[i] = !reset && (state_q == ST_IDLE) && grant_vld_d && (int'(grant_d) == i);
    end
  end

  // DECERR response built from the request still held on the TX register.
  always_comb begin
    rsp_synth_d          = '0;
    rsp_synth_d[31:0]    = tx_data_q[31:0] + 32'd2;
    rsp_synth_d[95:32]   = tx_data_q[95:32];
    if (tx_data_q[31:0] == TYPE_WRITE_REQ) begin
      rsp_synth_d[127:96] = tx_data_q[127:96];
    end
    rsp_synth_d[159:128] = RESP_DECERR;
  end

  assign req_type_ok_d = (req_data_d[31:0] == TYPE_READ_REQ) || (req_data_d[31:0] == TYPE_WRITE_REQ);
  assign drop_req_d    = (state_q == ST_IDLE) && grant_vld_d && !req_type_ok_d;
  // Any server beat outside WAIT_RSP has no transaction to belong to.
  assign drop_stale_d  = SRV_RX_TVALID && rx_ready_q && (state_q != ST_WAIT_RSP);
  // A response arriving in the expiry cycle takes priority over the timeout.
  assign timeout_evt_d = (state_q == ST_WAIT_RSP) && !SRV_RX_TVALID && (timer_q == TIMER_LAST);
  assign rsp_hs_d      = |(RSP_TREADY & rsp_valid_q);
  assign drop_inc_d    = {1'b0, drop_req_d} + {1'b0, drop_stale_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= GW'(NUM_REQ - 1);
      grant_q       <= '0;
      timer_q       <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= '0;
      rx_ready_q    <= 1'b0;
      timeout_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      rx_ready_q    <= 1'b1;
      drop_cnt_q    <= sat_add(drop_cnt_q, drop_inc_d);
      timeout_cnt_q <= sat_add(timeout_cnt_q, {1'b0, timeout_evt_d});
      case (state_q)
        ST_IDLE: begin
          if (grant_vld_d) begin
            last_grant_q <= grant_d;
            if (req_type_ok_d) begin
              grant_q    <= grant_d;
              tx_data_q  <= req_data_d;
              tx_valid_q <= 1'b1;
              state_q    <= ST_FWD;
            end
          end
        end
        ST_FWD: begin
          if (SRV_TX_TREADY) begin
            tx_valid_q <= 1'b0;
            timer_q    <= '0;
            state_q    <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (SRV_RX_TVALID) begin
            rsp_data_q  <= SRV_RX_TDATA;
            rsp_valid_q <= onehot(grant_q);
            state_q     <= ST_DELIVER;
          end else if (timer_q == TIMER_LAST) begin
            rsp_data_q  <= rsp_synth_d;
            rsp_valid_q <= onehot(grant_q);
            state_q     <= ST_DELIVER;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        ST_DELIVER: begin
          if (rsp_hs_d) begin
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign SRV_TX_TDATA  = tx_data_q;
  assign SRV_TX_TVALID = tx_valid_q;
  assign SRV_TX_TLAST  = tx_valid_q;
  assign SRV_RX_TREADY = rx_ready_q;
  assign RSP_TDATA     = rsp_data_q;
  assign RSP_TVALID    = rsp_valid_q;
  assign RSP_TLAST     = |rsp_valid_q;
  assign TIMEOUT_COUNT = timeout_cnt_q;
  assign DROP_COUNT    = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aximm_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aximm_request_arbiter
// Purpose  : Self-checking bench for aximm_request_arbiter (2 requesters,
//            16-cycle timeout). A transaction-level model tracks the request in
//            flight and predicts every registered output each cycle; directed
//            tests add literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aximm_request_arbiter;

  localparam int NR = 2;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*256-1:0] REQ_TDATA;
  logic [NR-1:0]     REQ_TVALID;
  logic [NR-1:0]     REQ_TREADY;
  logic [255:0]      RSP_TDATA;
  logic [NR-1:0]     RSP_TVALID;
  logic              RSP_TLAST;
  logic [NR-1:0]     RSP_TREADY;
  logic [255:0]      SRV_TX_TDATA;
  logic              SRV_TX_TVALID;
  logic              SRV_TX_TLAST;
  logic              SRV_TX_TREADY;
  logic [255:0]      SRV_RX_TDATA;
  logic              SRV_RX_TVALID;
  logic              SRV_RX_TREADY;
  logic [15:0]       TIMEOUT_COUNT;
  logic [15:0]       DROP_COUNT;

  aximm_request_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .REQ_TDATA(REQ_TDATA), .REQ_TVALID(REQ_TVALID), .REQ_TREADY(REQ_TREADY),
    .RSP_TDATA(RSP_TDATA), .RSP_TVALID(RSP_TVALID), .RSP_TLAST(RSP_TLAST),
    .RSP_TREADY(RSP_TREADY),
    .SRV_TX_TDATA(SRV_TX_TDATA), .SRV_TX_TVALID(SRV_TX_TVALID),
    .SRV_TX_TLAST(SRV_TX_TLAST), .SRV_TX_TREADY(SRV_TX_TREADY),
    .SRV_RX_TDATA(SRV_RX_TDATA), .SRV_RX_TVALID(SRV_RX_TVALID),
    .SRV_RX_TREADY(SRV_RX_TREADY),
    .TIMEOUT_COUNT(TIMEOUT_COUNT), .DROP_COUNT(DROP_COUNT)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  function automatic void bound_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", nm);
  endfunction

  // ---------------- transaction-level model ----------------
  int           m_last;
  bit           m_fwd, m_wait, m_rsp;
  logic [255:0] m_fwd_data, m_rsp_data;
  int           m_owner, m_wait_n, m_drop, m_to;
  int           grant_log[$];
  int           tx_beats = 0;
  int           rsp_beats = 0;
  logic         rst_s;

  function automatic void model_clear();
    m_last = NR - 1; m_fwd = 0; m_wait = 0; m_rsp = 0;
    m_fwd_data = '0; m_rsp_data = '0; m_owner = 0; m_wait_n = 0;
    m_drop = 0; m_to = 0;
  endfunction

  function automatic int rr_pick(input logic [NR-1:0] v);
    for (int k = 1; k <= NR; k++) begin
      if (v[(m_last + k) % NR]) return (m_last + k) % NR;
    end
    return -1;
  endfunction

  function automatic logic [255:0] decerr(input logic [255:0] req);
    logic [255:0] r;
    r = '0;
    r[31:0]    = req[31:0] + 32'd2;
    r[95:32]   = req[95:32];
    r[127:96]  = (req[31:0] == 32'd2) ? req[127:96] : 32'd0;
    r[159:128] = 32'd3;
    return r;
  endfunction

  always @(posedge clk) rst_s <= reset;

  always @(negedge clk) begin
    logic [NR-1:0] oh;
    logic [31:0]   typ;
    int            g;
    bit            idle, was_wait;
    if (rst_s) begin
      chk("rst_tx_tvalid", 256'(SRV_TX_TVALID), 256'(0));
      chk("rst_tx_tdata",  SRV_TX_TDATA, 256'(0));
      chk("rst_rsp_tvalid", 256'(RSP_TVALID), 256'(0));
      chk("rst_rsp_tlast", 256'(RSP_TLAST), 256'(0));
      chk("rst_rsp_tdata", RSP_TDATA, 256'(0));
      chk("rst_rx_tready", 256'(SRV_RX_TREADY), 256'(0));
      chk("rst_timeout_cnt", 256'(TIMEOUT_COUNT), 256'(0));
      chk("rst_drop_cnt", 256'(DROP_COUNT), 256'(0));
    end else begin
      chk("tx_tvalid", 256'(SRV_TX_TVALID), 256'(m_fwd));
      chk("tx_tlast",  256'(SRV_TX_TLAST),  256'(m_fwd));
      if (m_fwd) chk("tx_tdata", SRV_TX_TDATA, m_fwd_data);
      oh = '0;
      if (m_rsp) oh[m_owner] = 1'b1;
      chk("rsp_tvalid", 256'(RSP_TVALID), 256'(oh));
      chk("rsp_tlast",  256'(RSP_TLAST),  256'(m_rsp));
      if (m_rsp) chk("rsp_tdata", RSP_TDATA, m_rsp_data);
      chk("rx_tready", 256'(SRV_RX_TREADY), 256'(1));
      chk("timeout_cnt", 256'(TIMEOUT_COUNT), 256'(m_to));
      chk("drop_cnt", 256'(DROP_COUNT), 256'(m_drop));
    end
    if (reset) begin
      chk("req_tready_in_rst", 256'(REQ_TREADY), 256'(0));
      model_clear();
    end else begin
      idle = !m_fwd && !m_wait && !m_rsp;
      g    = idle ? rr_pick(REQ_TVALID) : -1;
      oh   = '0;
      if (g >= 0) oh[g] = 1'b1;
      chk("req_tready", 256'(REQ_TREADY), 256'(oh));
      was_wait = m_wait;
      if (m_rsp && RSP_TREADY[m_owner]) begin
        m_rsp = 0;
        rsp_beats++;
      end
      if (m_wait) begin
        if (SRV_RX_TVALID) begin
          m_rsp_data = SRV_RX_TDATA; m_rsp = 1; m_wait = 0;
        end else if (m_wait_n == TO - 1) begin
          m_rsp_data = decerr(m_fwd_data); m_rsp = 1; m_wait = 0;
          if (m_to < 16'hFFFF) m_to++;
        end else begin
          m_wait_n++;
        end
      end
      if (m_fwd && SRV_TX_TREADY) begin
        m_fwd = 0; m_wait = 1; m_wait_n = 0;
        tx_beats++;
      end
      if (!rst_s && SRV_RX_TVALID && !was_wait && m_drop < 16'hFFFF) m_drop++;
      if (g >= 0) begin
        grant_log.push_back(g);
        m_last = g;
        typ = REQ_TDATA[g*256 +: 32];
        if (typ == 32'd1 || typ == 32'd2) begin
          m_fwd = 1; m_fwd_data = REQ_TDATA[g*256 +: 256]; m_owner = g;
        end else if (m_drop < 16'hFFFF) begin
          m_drop++;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [255:0] mk(input int typ, input logic [63:0] addr,
                                      input logic [31:0] data, input logic [31:0] resp);
    logic [255:0] d;
    d = '0;
    d[31:0] = 32'(typ); d[95:32] = addr; d[127:96] = data; d[159:128] = resp;
    return d;
  endfunction

  task automatic do_req(input int r, input logic [255:0] d, output int waits);
    bit ok;
    ok = 0; waits = 0;
    REQ_TDATA[r*256 +: 256] = d;
    REQ_TVALID[r] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (REQ_TREADY[r]) ok = 1; else waits++;
      step();
    end
    REQ_TVALID[r] = 1'b0;
    if (!ok) bound_fail("req_handshake");
  endtask

  task automatic srv_accept(input int dly);
    bit ok;
    ok = 0;
    SRV_TX_TREADY = 1'b0;
    repeat (dly) step();
    SRV_TX_TREADY = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (SRV_TX_TVALID) ok = 1;
      step();
    end
    SRV_TX_TREADY = 1'b0;
    if (!ok) bound_fail("srv_tx_handshake");
  endtask

  task automatic srv_beat(input int dly, input logic [255:0] d);
    repeat (dly) step();
    SRV_RX_TDATA  = d;
    SRV_RX_TVALID = 1'b1;
    step();
    SRV_RX_TVALID = 1'b0;
  endtask

  task automatic take_rsp(input logic [NR-1:0] mask, input int dly);
    bit ok;
    ok = 0;
    RSP_TREADY = '0;
    repeat (dly) step();
    RSP_TREADY = mask;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (|(RSP_TVALID & mask)) ok = 1;
      step();
    end
    RSP_TREADY = '0;
    if (!ok) bound_fail("rsp_handshake");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int w, tx0, rs0;
    logic [255:0] d;
    model_clear();
    reset = 1'b1; REQ_TDATA = '0; REQ_TVALID = '0; RSP_TREADY = '0;
    SRV_TX_TREADY = 1'b0; SRV_RX_TDATA = '0; SRV_RX_TVALID = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_rsp_tvalid", 256'(RSP_TVALID), 256'(0));
    chk("reset_req_tready", 256'(REQ_TREADY), 256'(0));
    chk("reset_rx_tready", 256'(SRV_RX_TREADY), 256'(0));
    step();
    reset = 1'b0;
    repeat (2) step();

    // Fairness: both requesters hold WRITE_REQ continuously.
    grant_log.delete();
    REQ_TDATA[0 +: 256]   = mk(2, 64'h100, 32'hA0, 0);
    REQ_TDATA[256 +: 256] = mk(2, 64'h200, 32'hB1, 0);
    REQ_TVALID = 2'b11;
    for (int i = 0; i < 6; i++) begin
      srv_accept(0);
      srv_beat(1, mk(4, 64'(i), 32'(i), 0));
      take_rsp(2'b11, 0);
    end
    REQ_TVALID = '0;
    chk("fair_count", 256'(grant_log.size()), 256'(6));
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      chk("fair_grant", 256'(grant_log[i]), 256'(i % 2));
    step();

    // Single READ from requester 0.
    do_req(0, mk(1, 64'h10_0000_0040, 0, 0), w);
    @(negedge clk);
    chk("t1_tx_valid_n1", 256'(SRV_TX_TVALID), 256'(1));
    step();
    srv_accept(0);
    SRV_RX_TDATA = mk(3, 64'h10_0000_0040, 32'hDEADBEEF, 0);
    SRV_RX_TVALID = 1'b1;
    @(negedge clk);
    chk("t1_rsp_not_yet", 256'(RSP_TVALID), 256'(0));
    step();
    SRV_RX_TVALID = 1'b0;
    @(negedge clk);
    chk("t1_rsp_tvalid", 256'(RSP_TVALID), 256'(2'b01));
    chk("t1_word3", 256'(RSP_TDATA[127:96]), 256'(32'hDEADBEEF));
    step();
    take_rsp(2'b01, 0);

    // Timeout: server silent after accepting a WRITE.
    do_req(0, mk(2, 64'h20, 32'h5, 0), w);
    srv_accept(0);
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      chk("to_early", 256'(RSP_TVALID), 256'(0));
    end
    @(negedge clk);
    chk("to_rsp_tvalid", 256'(RSP_TVALID), 256'(2'b01));
    chk("to_word0", 256'(RSP_TDATA[31:0]), 256'(4));
    chk("to_addr", 256'(RSP_TDATA[95:32]), 256'(64'h20));
    chk("to_word3", 256'(RSP_TDATA[127:96]), 256'(5));
    chk("to_word4", 256'(RSP_TDATA[159:128]), 256'(3));
    chk("to_count", 256'(TIMEOUT_COUNT), 256'(1));
    step();
    take_rsp(2'b01, 0);
    repeat (3) step();
    srv_beat(0, mk(4, 64'h20, 0, 0));
    @(negedge clk);
    chk("late_drop", 256'(DROP_COUNT), 256'(1));
    chk("late_no_rsp", 256'(RSP_TVALID), 256'(0));
    step();

    // Response in the same cycle the timer expires wins.
    do_req(1, mk(1, 64'h30, 0, 0), w);
    srv_accept(0);
    srv_beat(TO - 1, mk(3, 64'h30, 32'h1234, 0));
    @(negedge clk);
    chk("edge_rsp_tvalid", 256'(RSP_TVALID), 256'(2'b10));
    chk("edge_word3", 256'(RSP_TDATA[127:96]), 256'(32'h1234));
    chk("edge_no_timeout", 256'(TIMEOUT_COUNT), 256'(1));
    step();
    take_rsp(2'b10, 0);

    // Malformed request (type 7) from requester 1.
    do_req(1, mk(7, 64'h40, 0, 0), w);
    chk("bad_accept_cycles", 256'(w), 256'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bad_no_tx", 256'(SRV_TX_TVALID), 256'(0));
    end
    chk("bad_drop", 256'(DROP_COUNT), 256'(2));
    step();
    do_req(0, mk(2, 64'h44, 32'h77, 0), w);
    srv_accept(0);
    srv_beat(2, mk(4, 64'h44, 0, 0));
    take_rsp(2'b01, 0);

    // Backpressure on both server TX and response.
    tx0 = tx_beats; rs0 = rsp_beats;
    do_req(0, mk(2, 64'h50, 32'hCAFE, 0), w);
    srv_accept(10);
    srv_beat(1, mk(4, 64'h50, 0, 0));
    take_rsp(2'b01, 10);
    repeat (3) step();
    chk("bp_tx_beats", 256'(tx_beats - tx0), 256'(1));
    chk("bp_rsp_beats", 256'(rsp_beats - rs0), 256'(1));

    // Reset while waiting for the server.
    do_req(0, mk(1, 64'h60, 0, 0), w);
    srv_accept(0);
    repeat (3) step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("mid_rst_tx", 256'(SRV_TX_TVALID), 256'(0));
    chk("mid_rst_rsp", 256'(RSP_TVALID), 256'(0));
    chk("mid_rst_cnt", 256'({TIMEOUT_COUNT, DROP_COUNT}), 256'(0));
    step();
    reset = 1'b0;
    repeat (2) step();
    srv_beat(0, mk(3, 64'h60, 0, 0));
    @(negedge clk);
    chk("post_rst_stale", 256'(DROP_COUNT), 256'(1));
    step();
    do_req(1, mk(2, 64'h70, 32'h9, 0), w);
    srv_accept(0);
    srv_beat(1, mk(4, 64'h70, 32'h9, 0));
    d = mk(4, 64'h70, 32'h9, 0);
    @(negedge clk);
    chk("post_rst_rsp", RSP_TDATA, d);
    step();
    take_rsp(2'b10, 0);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
